// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - CPU write side, uart_tx handshake and status bundle for uart_tx_queue
interface uart_tx_queue_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_overflow;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active;
  logic              tx_done;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              overflow;

  // Environment side: CPU store port plus the uart_tx serializer
  modport master (
    output wr_en, wr_data, clr_overflow, tx_active, tx_done,
    input  tx_dv, tx_byte, full, empty, count, busy, overflow
  );

  // Queue side
  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_active, tx_done,
    output tx_dv, tx_byte, full, empty, count, busy, overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - TX byte FIFO and uart_tx launch sequencer; TXQ_DROP_OLDEST_EN selects overwrite-oldest on full
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];

  logic full_w;
  logic empty_w;
  logic pop_w;
  logic push_w;
  logic drop_w;
  logic reject_w;

  // tx_active is informational only; the sequencer keys off tx_done
  logic unused_tx_active;
  assign unused_tx_active = bus.tx_active;

  // Full/empty come from the registered count only, so the full decision
  // always uses the pre-pop occupancy of this cycle
  always_comb begin
    full_w  = (count_q == FULL_COUNT);
    empty_w = (count_q == '0);
    pop_w   = (state_q == ST_IDLE) && !empty_w;
`ifdef TXQ_DROP_OLDEST_EN
    // A same-cycle pop frees the oldest slot, so the push lands normally;
    // otherwise the oldest entry is overwritten and both pointers advance
    push_w   = bus.wr_en && (!full_w || pop_w);
    drop_w   = bus.wr_en && full_w && !pop_w;
    reject_w = drop_w;
`else
    push_w   = bus.wr_en && !full_w;
    drop_w   = 1'b0;
    reject_w = bus.wr_en && full_w;
`endif
  end

  // Storage, pointers, occupancy, sticky overflow and the launch byte
  always_comb begin
    mem_d = mem_q;
    if (push_w || drop_w) begin
      mem_d[wr_ptr_q] = bus.wr_data;
    end
    wr_ptr_d  = (push_w || drop_w) ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = (pop_w || drop_w) ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d   = count_q + {{ADDR_W{1'b0}}, push_w} - {{ADDR_W{1'b0}}, pop_w};
    overflow_d = overflow_q;
    if (reject_w) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
    tx_byte_d = pop_w ? mem_q[rd_ptr_q] : tx_byte_q;
  end

  // Launch sequencer: pop in IDLE, strobe once in LAUNCH, wait for uart_tx done
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_w) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_byte_q  <= tx_byte_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.tx_dv    = (state_q == ST_LAUNCH);
  assign bus.tx_byte  = tx_byte_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != ST_IDLE) || !empty_w;
  assign bus.overflow = overflow_q;

endmodule
